// File: rtl/car_drive_responder_if.sv
// Command handshake between the elevator controller FSM (master) and the
// car-side drive responder (slave).
interface car_drive_responder_if #(
  parameter int FLOOR_W = 2
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [FLOOR_W-1:0] cmd_floor;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_floor,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_floor,
    output cmd_ready
  );
endinterface

// File: rtl/car_drive_responder.sv
// Car-side drive responder for the elevator controller.
// Accepts one GOTO/OPEN command at a time and models travel and door timing
// with down-counters that fire on terminal count zero.
// Optional build macro: DOOR_REOPEN_EN (obstruct restarts the door timer).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// MOVE  | travelling toward the latched target, one floor per period
// DOOR  | door held open until the door timer expires
module car_drive_responder #(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  car_drive_responder_if.slave cmd,
  input  logic                 obstruct,
  output logic [FLOOR_W-1:0]   floor,
  output logic                 moving_up,
  output logic                 moving_down,
  output logic                 door_open,
  output logic                 arrive,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0]   FLOORS_V    = (FLOOR_W+1)'(FLOORS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic [FLOOR_W-1:0] step_floor;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               up_d, dn_d, door_d;
  logic               arrive_d, done_d, err_d;
  logic               accept;
  logic               bad_floor;
  logic               reopen;

`ifdef DOOR_REOPEN_EN
  assign reopen = obstruct;
`else
  // Door timing is fixed in this build; the sensor input is left dangling.
  logic unused_obstruct;
  assign unused_obstruct = obstruct;
  assign reopen          = 1'b0;
`endif

  assign cmd.cmd_ready = (state_q == IDLE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign bad_floor     = ({1'b0, cmd.cmd_floor} >= FLOORS_V);

  // Next-state and next-output logic for the responder FSM.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor;
    target_d   = target_q;
    cnt_d      = cnt_q;
    up_d       = moving_up;
    dn_d       = moving_down;
    door_d     = door_open;
    arrive_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    step_floor = moving_up ? (floor + FLOOR_W'(1)) : (floor - FLOOR_W'(1));

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd.cmd_op) begin
            state_d = DOOR;
            door_d  = 1'b1;
            cnt_d   = DOOR_LOAD;
          end else if (bad_floor) begin
            err_d = 1'b1;
          end else if (cmd.cmd_floor == floor) begin
            done_d = 1'b1;
          end else begin
            state_d  = MOVE;
            target_d = cmd.cmd_floor;
            cnt_d    = TRAVEL_LOAD;
            if (cmd.cmd_floor > floor) begin
              up_d = 1'b1;
            end else begin
              dn_d = 1'b1;
            end
          end
        end
      end

      MOVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          floor_d  = step_floor;
          arrive_d = 1'b1;
          if (step_floor == target_q) begin
            done_d  = 1'b1;
            up_d    = 1'b0;
            dn_d    = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = TRAVEL_LOAD;
          end
        end
      end

      DOOR: begin
        // An obstruction at the terminal edge still wins: done is deferred.
        if (reopen) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          door_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        door_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset re-homes the car to floor 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      floor       <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      arrive      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor       <= floor_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      moving_up   <= up_d;
      moving_down <= dn_d;
      door_open   <= door_d;
      arrive      <= arrive_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_car_drive_responder.sv
// Directed bench for car_drive_responder with FLOORS=4, FLOOR_W=3,
// TRAVEL_CYCLES=4, DOOR_CYCLES=6. Outputs are sampled on the falling edge;
// k=0 is the sample right after the accepting rising edge.
module tb_car_drive_responder;

  localparam int FLOORS  = 4;
  localparam int FLOOR_W = 3;
  localparam int TRAVEL  = 4;
  localparam int DOORC   = 6;

`ifdef DOOR_REOPEN_EN
  localparam int OBST_END = 9;
`else
  localparam int OBST_END = 6;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               obstruct = 1'b0;
  logic [FLOOR_W-1:0] floor;
  logic               moving_up, moving_down, door_open, arrive, done, err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {floor, up, down, door, arrive, done, err, ready}
  logic [9:0] obs;
  logic [9:0] want;

  car_drive_responder_if #(.FLOOR_W(FLOOR_W)) cmd_if ();

  car_drive_responder #(
    .FLOORS       (FLOORS),
    .FLOOR_W      (FLOOR_W),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOORC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .obstruct   (obstruct),
    .floor      (floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .arrive     (arrive),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign obs = {floor, moving_up, moving_down, door_open, arrive, done, err, cmd_if.cmd_ready};

  // Present a command for one accepting edge; returns at the k=0 sample.
  task automatic issue(input logic op, input logic [FLOOR_W-1:0] fl);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_floor = fl;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_floor = '0;
  endtask

  task automatic test_reset();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 1'b0;
    cmd_if.cmd_floor = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    want = {3'd0, 6'b000000, 1'b1};
    total_cnt++;
    if (obs !== want) $display("FAIL reset got=%b want=%b", obs, want);
    else pass_cnt++;
  endtask

  task automatic test_goto_up();
    issue(1'b0, 3'd3);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      want = {(k >= 12) ? 3'd3 : 3'(k / TRAVEL), (k < 12), 1'b0, 1'b0,
              (k > 0 && k <= 12 && (k % TRAVEL) == 0), (k == 12), 1'b0, (k >= 12)};
      total_cnt++;
      if (obs !== want) $display("FAIL goto_up k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_goto_down();
    issue(1'b0, 3'd1);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      want = {(k >= 8) ? 3'd1 : ((k >= 4) ? 3'd2 : 3'd3), 1'b0, (k < 8), 1'b0,
              (k == 4 || k == 8), (k == 8), 1'b0, (k >= 8)};
      total_cnt++;
      if (obs !== want) $display("FAIL goto_down k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_open();
    issue(1'b1, 3'd0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) @(negedge clk);
      want = {3'd1, 1'b0, 1'b0, (k < DOORC), 1'b0, (k == DOORC), 1'b0, (k >= DOORC)};
      total_cnt++;
      if (obs !== want) $display("FAIL open k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
    end
  endtask

  // obstruct is high only across the rising edge A+3.
  task automatic test_obstruct();
    issue(1'b1, 3'd2);
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge clk);
      want = {3'd1, 1'b0, 1'b0, (k < OBST_END), 1'b0, (k == OBST_END), 1'b0, (k >= OBST_END)};
      total_cnt++;
      if (obs !== want) $display("FAIL obstruct k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
      if (k == 2) obstruct = 1'b1;
      if (k == 3) obstruct = 1'b0;
    end
  endtask

  task automatic test_err();
    issue(1'b0, 3'b101);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge clk);
      want = {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == 0), 1'b1};
      total_cnt++;
      if (obs !== want) $display("FAIL err k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_same_floor();
    issue(1'b0, 3'd1);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge clk);
      want = {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, (k == 0), 1'b0, 1'b1};
      total_cnt++;
      if (obs !== want) $display("FAIL same_floor k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
    end
  endtask

  // GOTO 3 from floor 1, then GOTO 0 held on the bus throughout the move.
  task automatic test_back_to_back();
    logic [2:0] fl_e;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 1'b0;
    cmd_if.cmd_floor = 3'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_floor = 3'd0;
    for (int k = 0; k <= 23; k++) begin
      if (k > 0) @(negedge clk);
      if      (k < 4)  fl_e = 3'd1;
      else if (k < 8)  fl_e = 3'd2;
      else if (k < 13) fl_e = 3'd3;
      else if (k < 17) fl_e = 3'd2;
      else if (k < 21) fl_e = 3'd1;
      else             fl_e = 3'd0;
      want = {fl_e, (k < 8), (k >= 9 && k < 21), 1'b0,
              (k == 4 || k == 8 || k == 13 || k == 17 || k == 21),
              (k == 8 || k == 21), 1'b0, (k == 8 || k >= 21)};
      total_cnt++;
      if (obs !== want) $display("FAIL back_to_back k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
      if (k == 9) cmd_if.cmd_valid = 1'b0;
    end
  endtask

  // rst is sampled at edge A+6 of a GOTO 3 from floor 0.
  task automatic test_reset_mid();
    issue(1'b0, 3'd3);
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 5)
        want = {3'(k / TRAVEL), 1'b1, 1'b0, 1'b0, (k == 4), 1'b0, 1'b0, 1'b0};
      else
        want = {3'd0, 6'b000000, 1'b1};
      total_cnt++;
      if (obs !== want) $display("FAIL reset_mid k=%0d got=%b want=%b", k, obs, want);
      else pass_cnt++;
      if (k == 5) rst = 1'b1;
      if (k == 6) rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_goto_up();
    test_goto_down();
    test_open();
    test_obstruct();
    test_err();
    test_same_floor();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
